imem_fetch_responder: RTL

Instruction-memory responder serving the fetch stage. Holds the 256-byte program store. For each PC request it returns the opcode byte and, when the opcode takes one, the following immediate byte. It also reports whether the instruction is two bytes long, so the fetch stage can advance PC by 1 or 2.

---
 rtl/imem_fetch_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: 256x8 program store that returns a one- or two-byte instruction per PC request.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (no wrap past 8'hFF, adds addr_err).  Rev 1.0
`default_nettype none

module imem_fetch_responder #(
  parameter logic [15:0] IMM_OPS = 16'h1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  input  logic       fetch_req,
  input  logic       flush,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic [7:0] instruction,
  output logic [7:0] immediate,
  output logic       immediate_enabled,
  output logic       valid,
`ifdef IMEM_BOUNDS_CHECK_EN
  output logic       addr_err,
`endif
  output logic       busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_IMM  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] imm_q, imm_d;
  logic       imm_en_q, imm_en_d;
  logic       valid_q, valid_d;
  logic [7:0] addr_q, addr_d;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic       err_q, err_d;
`endif

  logic [7:0] mem_q [256];
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wrap_hit;

  // Single read port: the PC in IDLE, the byte after the opcode in IMM.
  assign rd_addr  = (state_q == S_IMM) ? addr_q + 8'd1 : pc;
  assign rd_data  = mem_q[rd_addr];
  assign wrap_hit = (addr_q == 8'hFF);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    imm_en_d = imm_en_q;
    valid_d  = 1'b0;
    addr_d   = addr_q;
`ifdef IMEM_BOUNDS_CHECK_EN
    err_d    = err_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else if (!load_en) begin
      case (state_q)
        S_IDLE: begin
          if (fetch_req) begin
            instr_d = rd_data;
            addr_d  = pc;
            if (IMM_OPS[rd_data[7:4]]) begin
              state_d = S_IMM;
            end else begin
              imm_d    = 8'h00;
              imm_en_d = 1'b0;
              valid_d  = 1'b1;
`ifdef IMEM_BOUNDS_CHECK_EN
              err_d    = 1'b0;
`endif
            end
          end
        end
        S_IMM: begin
          imm_en_d = 1'b1;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
`ifdef IMEM_BOUNDS_CHECK_EN
          imm_d    = wrap_hit ? 8'h00 : rd_data;
          err_d    = wrap_hit;
`else
          imm_d    = rd_data;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= 8'h00;
      imm_q    <= 8'h00;
      imm_en_q <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= 8'h00;
`ifdef IMEM_BOUNDS_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      imm_en_q <= imm_en_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
`ifdef IMEM_BOUNDS_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Program store is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign instruction       = instr_q;
  assign immediate         = imm_q;
  assign immediate_enabled = imm_en_q;
  assign valid             = valid_q;
  assign busy              = (state_q == S_IMM);
`ifdef IMEM_BOUNDS_CHECK_EN
  assign addr_err          = err_q;
`else
  logic unused_wrap;
  assign unused_wrap       = wrap_hit;
`endif

endmodule

`default_nettype wire
